// File: rtl/multiplier.sv
// Radix-2 Booth multiplier, 4x4 signed operands to an 8-bit signed product.
// One Booth step per clock after start drops; the product is captured on the 4th step.
module multiplier (
  output logic [7:0] Output,
  output logic       busy,
  input  logic [3:0] Multiplicand,
  input  logic [3:0] Multiplier,
  input  logic       clk,
  input  logic       start,
  output logic [7:0] count,
  output logic [3:0] s,
  output logic [3:0] d,
  input  logic       rst
);

  logic [3:0] m_reg;
  logic [4:0] a_reg;
  logic [3:0] q_reg;
  logic       qm1;
  logic [2:0] step;

  logic [4:0] m_ext;
  logic [4:0] a_sum;
  logic [4:0] a_next;
  logic [3:0] q_next;

  // The fifth accumulator bit keeps -8 x -8 from overflowing the partial sum.
  assign m_ext = {m_reg[3], m_reg};

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    a_sum = a_reg;
    case ({q_reg[0], qm1})
      2'b01:   a_sum = a_reg + m_ext;
      2'b10:   a_sum = a_reg - m_ext;
      default: a_sum = a_reg;
    endcase
    // Arithmetic right shift of {A,Q,Qm1}; the new Qm1 is simply the old Q[0].
    a_next = {a_sum[4], a_sum[4:1]};
    q_next = {a_sum[0], q_reg[3:1]};
  end

  // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Output <= 8'd0;
      busy   <= 1'b0;
      m_reg  <= 4'd0;
      a_reg  <= 5'd0;
      q_reg  <= 4'd0;
      qm1    <= 1'b0;
      step   <= 3'd0;
    end else if (start) begin
      m_reg <= Multiplicand;
      a_reg <= 5'd0;
      q_reg <= Multiplier;
      qm1   <= 1'b0;
      step  <= 3'd0;
      busy  <= 1'b1;
    end else if (busy && (step < 3'd4)) begin
      a_reg <= a_next;
      q_reg <= q_next;
      qm1   <= q_reg[0];
      step  <= step + 3'd1;
      if (step == 3'd3) begin
        Output <= {a_next[3:0], q_next};
        busy   <= 1'b0;
      end
    end
  end

  assign s     = a_reg[3:0];
  assign d     = q_reg;
  assign count = {5'd0, step};

endmodule

// File: tb/tb_multiplier.sv
// Self-checking bench for the Booth multiplier: directed scenarios, random operations
// with operand noise during the run, and an exhaustive sweep against a signed product.
module tb_multiplier;

  logic [7:0] Output;
  logic       busy;
  logic [3:0] Multiplicand;
  logic [3:0] Multiplier;
  logic       clk;
  logic       start;
  logic [7:0] count;
  logic [3:0] s;
  logic [3:0] d;
  logic       rst;

  int checks = 0;
  int errors = 0;
  logic [7:0] last_out = 8'd0;

  multiplier dut (
    .Output      (Output),
    .busy        (busy),
    .Multiplicand(Multiplicand),
    .Multiplier  (Multiplier),
    .clk         (clk),
    .start       (start),
    .count       (count),
    .s           (s),
    .d           (d),
    .rst         (rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_prod(input logic [3:0] m, input logic [3:0] q);
    int p;
    p = int'($signed(m)) * int'($signed(q));
    return p[7:0];
  endfunction

  // Called at a falling edge; leaves start high across 'holds' rising edges.
  task automatic do_load(input logic [3:0] m, input logic [3:0] q, input int holds);
    Multiplicand = m;
    Multiplier   = q;
    start        = 1'b1;
    repeat (holds) @(negedge clk);
    start = 1'b0;
    check("load_busy",  {7'd0, busy}, 8'd1);
    check("load_count", count, 8'd0);
    check("load_s",     {4'd0, s}, 8'd0);
    check("load_d",     {4'd0, d}, {4'd0, q});
    check("load_out",   Output, last_out);
  endtask

  // Operand inputs are scrambled before each step: they must be ignored while running.
  task automatic do_steps(input int n, input bit zchk);
    for (int i = 1; i <= n; i++) begin
      Multiplicand = 4'($urandom);
      Multiplier   = 4'($urandom);
      @(negedge clk);
      check("step_count", count, 8'(i));
      check("step_busy",  {7'd0, busy}, (i < 4) ? 8'd1 : 8'd0);
      if (i < 4) check("step_out_hold", Output, last_out);
      if (zchk) begin
        check("zero_s", {4'd0, s}, 8'd0);
        check("zero_d", {4'd0, d}, 8'd0);
      end
    end
  endtask

  task automatic run_op(input logic [3:0] m, input logic [3:0] q, input int holds, input bit zchk);
    do_load(m, q, holds);
    do_steps(4, zchk);
    last_out = ref_prod(m, q);
    check("product", Output, last_out);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    Multiplicand = 4'd0;
    Multiplier = 4'd0;
    #12;
    check("rst_out",   Output, 8'd0);
    check("rst_busy",  {7'd0, busy}, 8'd0);
    check("rst_count", count, 8'd0);
    check("rst_s",     {4'd0, s}, 8'd0);
    check("rst_d",     {4'd0, d}, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_busy",  {7'd0, busy}, 8'd0);
    check("idle_count", count, 8'd0);

    // start held over two edges, then exactly four busy edges
    run_op(4'd3, 4'd2, 2, 1'b0);
    check("p_3x2", Output, 8'd6);

    run_op(4'h8, 4'h8, 1, 1'b0);
    check("p_m8xm8", Output, 8'h40);
    run_op(4'h8, 4'd7, 1, 1'b0);
    check("p_m8x7", Output, 8'hC8);
    run_op(4'd7, 4'hF, 1, 1'b0);
    check("p_7xm1", Output, 8'hF9);
    run_op(4'd5, 4'd0, 1, 1'b1);
    check("p_5x0", Output, 8'h00);

    // idle hold: product persists
    repeat (3) @(negedge clk);
    check("idle_hold_out",  Output, last_out);
    check("idle_hold_busy", {7'd0, busy}, 8'd0);

    // asynchronous reset mid-operation
    run_op(4'd6, 4'd5, 1, 1'b0);
    do_load(4'd6, 4'd5, 1);
    do_steps(2, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("arst_busy",  {7'd0, busy}, 8'd0);
    check("arst_count", count, 8'd0);
    check("arst_s",     {4'd0, s}, 8'd0);
    check("arst_d",     {4'd0, d}, 8'd0);
    check("arst_out",   Output, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    last_out = 8'd0;
    repeat (2) @(negedge clk);
    check("post_rst_busy", {7'd0, busy}, 8'd0);
    check("post_rst_out",  Output, 8'd0);
    run_op(4'd3, 4'd3, 1, 1'b0);
    check("p_3x3", Output, 8'd9);

    // restart mid-operation with new operands
    do_load(4'd2, 4'd3, 1);
    do_steps(2, 1'b0);
    do_load(4'd5, 4'hD, 1);
    do_steps(4, 1'b0);
    last_out = ref_prod(4'd5, 4'hD);
    check("restart_prod", Output, last_out);
    check("p_5xm3", Output, 8'hF1);

    // random operations with random hold lengths
    for (int k = 0; k < 40; k++)
      run_op(4'($urandom), 4'($urandom), int'($urandom_range(1, 3)), 1'b0);

    // exhaustive sweep
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        run_op(4'(i), 4'(j), 1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multiplier.md
MULTIPLIER -- requirements
Module: multiplier

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named as follows.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
REQ-002 The block SHALL have the following data and control ports.
- Output  out  8  signed product; valid whenever busy=0 after a completed operation
- busy  out  1  high while an operation is loaded or in progress
- Multiplicand  in  4  signed two's-complement operand M
- Multiplier  in  4  signed two's-complement operand Q
- start  in  1  level-sensitive load/run request
- count  out  8  number of Booth steps completed in the current operation (0..4)
- s  out  4  debug: accumulator A[3:0]
- d  out  4  debug: multiplier/shift register Q[3:0]
REQ-003 Positional port order SHALL be: Output, busy, Multiplicand, Multiplier, clk, start, count, s, d, rst.
REQ-004 The block SHALL have no parameters; operand width is fixed at 4 and product width at 8.

Function
REQ-005 The block SHALL implement radix-2 Booth multiplication, with Output = signed(Multiplicand) x signed(Multiplier) for all 256 operand pairs.
REQ-006 Internal state SHALL be:
- M: 4-bit multiplicand register
- A: 5-bit sign-extended accumulator
- Q: 4-bit register
- Qm1: 1-bit Booth bit
- step counter
- busy flag
REQ-007 LOAD: on a rising edge with start=1, the block SHALL set M<=Multiplicand, A<=0, Q<=Multiplier, Qm1<=0, count<=0 and busy<=1. This applies regardless of the current busy state, so start=1 mid-operation restarts the operation.
REQ-008 While start=1, the block SHALL reload on every edge; no Booth step executes while start is high.
REQ-009 RUN: on each rising edge with start=0, busy=1 and count<4, the block SHALL execute one Booth step.
- {Q[0],Qm1}=01: A<=A+sext(M).
- {Q[0],Qm1}=10: A<=A-sext(M).
- 00 or 11: A unchanged.
- Then arithmetic right shift of {A,Q,Qm1} by 1 (A[4] replicated), and count<=count+1.
REQ-010 On the edge that completes step 4, the block SHALL capture Output<={A,Q}[7:0] from the post-shift value and clear busy to 0 on that same edge.
REQ-011 Latency SHALL be exactly 4 clock edges after the first edge at which start is sampled 0 following a load; busy SHALL fall on the 4th such edge.
REQ-012 When idle (busy=0, start=0), all registers SHALL hold; Output SHALL keep the last product until the next completion.
REQ-013 Output SHALL NOT change during an operation; it updates only at completion (REQ-010) or on reset.
REQ-014 s SHALL equal A[3:0] and d SHALL equal Q at all times; count SHALL reflect the step counter zero-extended to 8 bits.
REQ-015 The 5-bit accumulator SHALL prevent overflow for M=-8, so that -8 x -8 yields +64 (8'h40).
REQ-016 Operand inputs SHALL be sampled only at LOAD; changes during RUN SHALL have no effect.

Reset
REQ-017 When rst=1, the block SHALL asynchronously clear Output, busy, count, A, Q, Qm1 and M to 0, so that s=0 and d=0.
REQ-018 rst SHALL take priority over start; asserting rst mid-operation SHALL abort the operation, leave busy=0 and Output=0, and the next start SHALL begin a fresh operation.
REQ-019 After rst deasserts, the block SHALL be idle until start=1 is sampled.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Hold start=1 over 2 edges with Multiplier=2, Multiplicand=3, then start=0 -> busy=1 for exactly 4 edges, count steps 1..4, then busy=0 and Output=8'd6.
- Multiplicand=-8, Multiplier=-8 -> Output=8'h40 (+64).
- Multiplicand=-8, Multiplier=7 -> Output=8'hC8 (-56); Multiplicand=7, Multiplier=-1 -> Output=8'hF9 (-7).
- Multiplier=0 with any Multiplicand -> Output=0, and A and Q remain 0 through all 4 steps.
- Assert rst after step 2 -> busy, count, s, d and Output are 0 immediately without waiting for a clock edge; a subsequent 3 x 3 operation yields 8'd9.
- Assert start=1 mid-operation with new operands 5 and -3 -> operation restarts, count returns to 0, and the final Output=8'hF1 (-15).
- Exhaustive sweep of all 256 operand pairs against a signed reference product.
